// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
// Build option: define AXIL_WSTRB_EN to add the WSTRB byte-strobe port to the top.
package axi4_lite_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axil_reg_file.sv
// Register array: one synchronous byte-enabled write port, one combinational read port.
// Out-of-range read indices return zero; the caller only writes mapped indices.
module axil_reg_file
    import axi4_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_we,
    input  logic [IDX_W-1:0]           i_widx,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [STRB_W-1:0]          i_wbe,
    input  logic [IDX_W-1:0]           i_ridx,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [DATA_W*NUM_REGS-1:0] o_regs
);

    logic [DATA_W*NUM_REGS-1:0] r_regs;

    // Byte-enabled write into the selected register; synchronous clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_regs <= '0;
        end else if (i_we) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (32'(i_widx) == 32'(i)) begin
                    for (int b = 0; b < int'(STRB_W); b++) begin
                        if (i_wbe[b]) begin
                            r_regs[DATA_W*i + 8*b +: 8] <= i_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Combinational read mux; returns pre-write contents during a same-edge write
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (32'(i_ridx) == 32'(i)) begin
                o_rdata = r_regs[DATA_W*i +: DATA_W];
            end
        end
    end

    assign o_regs = r_regs;

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers; independent write and read FSMs.
// Build option: AXIL_WSTRB_EN adds WSTRB[3:0]; without it every write covers all bytes.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [ADDR_W-1:0]          AWADDR,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [31:0]                WDATA,
`ifdef AXIL_WSTRB_EN
    input  logic [3:0]                 WSTRB,
`endif
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic [1:0]                 BRESP,
    output logic                       BVALID,
    input  logic                       BREADY,
    input  logic [ADDR_W-1:0]          ARADDR,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [31:0]                RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [32*NUM_REGS-1:0]     regs_o
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    w_state_e              r_wstate, w_wstate_nxt;
    r_state_e              r_rstate, w_rstate_nxt;

    logic [IDX_W-1:0]      r_widx;
    logic [DATA_W-1:0]     r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [1:0]            r_bresp;
    logic [DATA_W-1:0]     r_rdata;
    logic [1:0]            r_rresp;

    logic [IDX_W-1:0]      w_aw_idx;
    logic [IDX_W-1:0]      w_ar_idx;
    logic [STRB_W-1:0]     w_in_strb;
    logic                  w_commit;
    logic                  w_lat_addr;
    logic                  w_lat_data;
    logic [IDX_W-1:0]      w_cidx;
    logic [DATA_W-1:0]     w_cdata;
    logic [STRB_W-1:0]     w_cstrb;
    logic                  w_cmapped;
    logic                  w_ar_capture;
    logic                  w_rmapped;
    logic [DATA_W-1:0]     w_rf_rdata;
    logic                  w_unused_addr_lsbs;

    assign w_aw_idx  = AWADDR[ADDR_W-1:2];
    assign w_ar_idx  = ARADDR[ADDR_W-1:2];
    assign w_cmapped = 32'(w_cidx) < NUM_REGS;
    assign w_rmapped = 32'(w_ar_idx) < NUM_REGS;
    assign w_unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

`ifdef AXIL_WSTRB_EN
    assign w_in_strb = WSTRB;
`else
    assign w_in_strb = '1;
`endif

    assign BRESP = r_bresp;
    assign RDATA = r_rdata;
    assign RRESP = r_rresp;

    // Write and read FSM state registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    // Write FSM: next state, handshake readies and commit selection
    always_comb begin
        w_wstate_nxt = r_wstate;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        BVALID       = 1'b0;
        w_commit     = 1'b0;
        w_lat_addr   = 1'b0;
        w_lat_data   = 1'b0;
        w_cidx       = w_aw_idx;
        w_cdata      = WDATA;
        w_cstrb      = w_in_strb;
        case (r_wstate)
            W_IDLE: begin
                AWREADY = 1'b1;
                WREADY  = 1'b1;
                if (AWVALID && WVALID) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end else if (AWVALID) begin
                    w_lat_addr   = 1'b1;
                    w_wstate_nxt = W_ADDR;
                end else if (WVALID) begin
                    w_lat_data   = 1'b1;
                    w_wstate_nxt = W_DATA;
                end
            end
            W_ADDR: begin
                WREADY = 1'b1;
                w_cidx = r_widx;
                if (WVALID) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_DATA: begin
                AWREADY = 1'b1;
                w_cdata = r_wdata;
                w_cstrb = r_wstrb;
                if (AWVALID) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
        // Reset silences the bus interface and abandons any in-flight write
        if (ARESET) begin
            AWREADY    = 1'b0;
            WREADY     = 1'b0;
            BVALID     = 1'b0;
            w_commit   = 1'b0;
            w_lat_addr = 1'b0;
            w_lat_data = 1'b0;
        end
    end

    // Write-side holding registers and response code
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_widx  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_bresp <= RESP_OKAY;
        end else begin
            if (w_lat_addr) begin
                r_widx <= w_aw_idx;
            end
            if (w_lat_data) begin
                r_wdata <= WDATA;
                r_wstrb <= w_in_strb;
            end
            if (w_commit) begin
                r_bresp <= w_cmapped ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Read FSM: next state and handshake signals
    always_comb begin
        w_rstate_nxt = r_rstate;
        ARREADY      = 1'b0;
        RVALID       = 1'b0;
        w_ar_capture = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) begin
                    w_ar_capture = 1'b1;
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        if (ARESET) begin
            ARREADY      = 1'b0;
            RVALID       = 1'b0;
            w_ar_capture = 1'b0;
        end
    end

    // Read data/response capture on the AR handshake, held until taken
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_capture) begin
            r_rdata <= w_rmapped ? w_rf_rdata : '0;
            r_rresp <= w_rmapped ? RESP_OKAY : RESP_SLVERR;
        end
    end

    axil_reg_file #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_reg_file (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_we    (w_commit && w_cmapped),
        .i_widx  (w_cidx),
        .i_wdata (w_cdata),
        .i_wbe   (w_cstrb),
        .i_ridx  (w_ar_idx),
        .o_rdata (w_rf_rdata),
        .o_regs  (regs_o)
    );

endmodule
